// File: rtl/bool_chk_pkg.sv
// Shared definitions for the BOOL response checker: BFN truth-table codes,
// checker state encoding and the per-bit truth-table helper.
package bool_chk_pkg;

    localparam logic [3:0] BFN_AND = 4'b1000;
    localparam logic [3:0] BFN_OR  = 4'b1110;
    localparam logic [3:0] BFN_XOR = 4'b0110;
    localparam logic [3:0] BFN_A   = 4'b1010;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // One result bit: the truth-table entry selected by {b, a}.
    function automatic logic bfn_bit(input logic [3:0] bfn, input logic b, input logic a);
        return bfn[{b, a}];
    endfunction

endpackage

// File: rtl/bool_ref_model.sv
// Combinational golden model of the BOOL unit: every result bit is the BFN
// truth-table entry indexed by the matching {B, A} operand bits.
module bool_ref_model
    import bool_chk_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       bfn,
    output logic [WIDTH-1:0] exp_res
);

    // Per-bit truth-table lookup.
    always_comb begin
        exp_res = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            exp_res[i] = bfn_bit(bfn, b[i], a[i]);
        end
    end

endmodule

// File: rtl/bool_resp_checker.sv
// Two-stage BOOL response checker with pass/fail counters and first-error capture.
// Optional ERR_MASK output (sticky OR of got^exp) is enabled by BOOL_CHK_MASK_EN.
module bool_resp_checker
    import bool_chk_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       BFN,
    input  logic [WIDTH-1:0] BOOLO,
    input  logic             CLEAR,
    output logic             BUSY,
    output logic [CNT_W-1:0] PASS_CNT,
    output logic [CNT_W-1:0] FAIL_CNT,
    output logic             ERR_FLAG,
    output logic [WIDTH-1:0] ERR_A,
    output logic [WIDTH-1:0] ERR_B,
    output logic [WIDTH-1:0] ERR_GOT,
    output logic [WIDTH-1:0] ERR_EXP,
`ifdef BOOL_CHK_MASK_EN
    output logic [3:0]       ERR_BFN,
    output logic [WIDTH-1:0] ERR_MASK
`else
    output logic [3:0]       ERR_BFN
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic             accept_s;
    logic [WIDTH-1:0] exp_s;
    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [3:0]       s1_bfn_r;
    logic [WIDTH-1:0] s1_got_r;
    logic [WIDTH-1:0] s1_exp_r;
    logic             match_s;
    logic             mismatch_s;

    bool_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a       (A),
        .b       (B),
        .bfn     (BFN),
        .exp_res (exp_s)
    );

    // Ready is gated by reset so a master never sees a transfer while held in reset.
    assign IN_READY   = RESET_N && (state_r == ST_RUN) && !CLEAR;
    assign accept_s   = IN_VALID && IN_READY;
    assign match_s    = s1_valid_r && (s1_got_r == s1_exp_r);
    assign mismatch_s = s1_valid_r && (s1_got_r != s1_exp_r);
    assign BUSY       = s1_valid_r;

    // Stage 1 capture of the accepted tuple and its expected result.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_bfn_r   <= 4'b0000;
            s1_got_r   <= {WIDTH{1'b0}};
            s1_exp_r   <= {WIDTH{1'b0}};
        end else if (CLEAR) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_bfn_r   <= 4'b0000;
            s1_got_r   <= {WIDTH{1'b0}};
            s1_exp_r   <= {WIDTH{1'b0}};
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_a_r   <= A;
                s1_b_r   <= B;
                s1_bfn_r <= BFN;
                s1_got_r <= BOOLO;
                s1_exp_r <= exp_s;
            end
        end
    end

    // Saturating pass/fail counters.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PASS_CNT <= {CNT_W{1'b0}};
            FAIL_CNT <= {CNT_W{1'b0}};
        end else if (CLEAR) begin
            PASS_CNT <= {CNT_W{1'b0}};
            FAIL_CNT <= {CNT_W{1'b0}};
        end else begin
            if (match_s && (PASS_CNT != CNT_MAX)) begin
                PASS_CNT <= PASS_CNT + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (mismatch_s && (FAIL_CNT != CNT_MAX)) begin
                FAIL_CNT <= FAIL_CNT + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // First-mismatch capture; ERR_FLAG guards against overwriting it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ERR_FLAG <= 1'b0;
            ERR_A    <= {WIDTH{1'b0}};
            ERR_B    <= {WIDTH{1'b0}};
            ERR_BFN  <= 4'b0000;
            ERR_GOT  <= {WIDTH{1'b0}};
            ERR_EXP  <= {WIDTH{1'b0}};
        end else if (CLEAR) begin
            ERR_FLAG <= 1'b0;
            ERR_A    <= {WIDTH{1'b0}};
            ERR_B    <= {WIDTH{1'b0}};
            ERR_BFN  <= 4'b0000;
            ERR_GOT  <= {WIDTH{1'b0}};
            ERR_EXP  <= {WIDTH{1'b0}};
        end else if (mismatch_s && !ERR_FLAG) begin
            ERR_FLAG <= 1'b1;
            ERR_A    <= s1_a_r;
            ERR_B    <= s1_b_r;
            ERR_BFN  <= s1_bfn_r;
            ERR_GOT  <= s1_got_r;
            ERR_EXP  <= s1_exp_r;
        end
    end

`ifdef BOOL_CHK_MASK_EN
    // Sticky OR of differing bits across all mismatches.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ERR_MASK <= {WIDTH{1'b0}};
        end else if (CLEAR) begin
            ERR_MASK <= {WIDTH{1'b0}};
        end else if (mismatch_s) begin
            ERR_MASK <= ERR_MASK | (s1_got_r ^ s1_exp_r);
        end
    end
`endif

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; CLEAR always returns to RUN.
    always_comb begin
        state_nxt_s = state_r;
        if (CLEAR) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mismatch_s && (STOP_ON_ERR != 0)) begin
                        state_nxt_s = ST_HALT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_HALT: state_nxt_s = ST_HALT;
                default: state_nxt_s = ST_RUN;
            endcase
        end
    end

endmodule
